// File: rtl/rate_monitor_pkg.sv
// Shared definitions for the rate-limit monitor: FSM encoding, field widths
// and the saturating gap-requirement product.
package rate_monitor_pkg;

  localparam int unsigned LEN_W   = 16;
  localparam int unsigned GAP_W   = 24;
  localparam int unsigned SHIFT_W = 16;
  localparam int unsigned PROD_W  = LEN_W + SHIFT_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_PKT = 2'd1,
    ST_GAP    = 2'd2
  } mon_state_e;

  // Full 32-bit product, clamped to the 24-bit gap range.
  function automatic logic [GAP_W-1:0] sat_required(input logic [LEN_W-1:0]   len,
                                                    input logic [SHIFT_W-1:0] shift);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(len) * PROD_W'(shift);
    if (prod > PROD_W'({GAP_W{1'b1}})) begin
      return {GAP_W{1'b1}};
    end
    return GAP_W'(prod);
  endfunction

endpackage

// File: rtl/rate_monitor_sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != {WIDTH{1'b1}})) begin
      value_d = value_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/rate_monitor.sv
// Inline pacing checker: passes the module bus through untouched and flags
// packets whose preceding idle gap is shorter than len * thruput_shift.
module rate_monitor
  import rate_monitor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  enable_monitor,
  input  logic [15:0]           thruput_shift,
  input  logic                  clear_counters,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  violation_count,
  output logic [15:0]           last_pkt_len,
  output logic [23:0]           last_gap,
  output logic [23:0]           min_gap,
  output logic                  violation
);

  assign in_rdy   = out_rdy;
  assign out_data = in_data;
  assign out_ctrl = in_ctrl;
  assign out_wr   = in_wr;

  mon_state_e       state_q, state_d;
  logic             prev_ctrl_is_0_q, prev_ctrl_is_0_d;
  logic [GAP_W-1:0] required_q, required_d;
  logic [LEN_W-1:0] last_pkt_len_q, last_pkt_len_d;
  logic [GAP_W-1:0] last_gap_q, last_gap_d;
  logic [GAP_W-1:0] min_gap_q, min_gap_d;
  logic             violation_q, violation_d;

  logic             eop;
  logic [LEN_W-1:0] len_val, len_plus;
  logic [GAP_W-1:0] gap_val;
  logic             len_inc, len_clr, gap_inc, gap_clr, pkt_inc, viol_inc;

  sat_counter #(.WIDTH(LEN_W)) u_len (
    .clk(clk), .reset(reset), .inc(len_inc), .clr(len_clr), .value(len_val)
  );

  sat_counter #(.WIDTH(GAP_W)) u_gap (
    .clk(clk), .reset(reset), .inc(gap_inc), .clr(gap_clr), .value(gap_val)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt (
    .clk(clk), .reset(reset), .inc(pkt_inc), .clr(clear_counters), .value(pkt_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_viol (
    .clk(clk), .reset(reset), .inc(viol_inc), .clr(clear_counters), .value(violation_count)
  );

  assign eop      = in_wr && (in_ctrl != '0) && prev_ctrl_is_0_q;
  assign len_plus = (len_val == {LEN_W{1'b1}}) ? len_val : len_val + LEN_W'(1);

  // Length counter holds words seen so far in the current packet; zero outside one.
  always_comb begin
    state_d          = state_q;
    prev_ctrl_is_0_d = prev_ctrl_is_0_q;
    required_d       = required_q;
    last_pkt_len_d   = last_pkt_len_q;
    last_gap_d       = last_gap_q;
    min_gap_d        = min_gap_q;
    violation_d      = 1'b0;
    len_inc          = enable_monitor && in_wr;
    len_clr          = !enable_monitor;
    gap_inc          = 1'b0;
    gap_clr          = (state_q != ST_GAP);
    pkt_inc          = 1'b0;
    viol_inc         = 1'b0;

    if (in_wr) begin
      prev_ctrl_is_0_d = (in_ctrl == '0);
    end

    if (!enable_monitor) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_wr) begin
            state_d = ST_IN_PKT;
          end
        end
        ST_IN_PKT: begin
          if (eop) begin
            last_pkt_len_d = len_plus;
            pkt_inc        = 1'b1;
            required_d     = sat_required(len_plus, thruput_shift);
            len_clr        = 1'b1;
            state_d        = ST_GAP;
          end
        end
        ST_GAP: begin
          if (in_wr) begin
            last_gap_d = gap_val;
            if (gap_val < min_gap_q) begin
              min_gap_d = gap_val;
            end
            if (gap_val < required_q) begin
              viol_inc    = 1'b1;
              violation_d = 1'b1;
            end
            state_d = ST_IN_PKT;
          end else begin
            gap_inc = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (clear_counters) begin
      min_gap_d = {GAP_W{1'b1}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      prev_ctrl_is_0_q <= 1'b0;
      required_q       <= '0;
      last_pkt_len_q   <= '0;
      last_gap_q       <= '0;
      min_gap_q        <= {GAP_W{1'b1}};
      violation_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      prev_ctrl_is_0_q <= prev_ctrl_is_0_d;
      required_q       <= required_d;
      last_pkt_len_q   <= last_pkt_len_d;
      last_gap_q       <= last_gap_d;
      min_gap_q        <= min_gap_d;
      violation_q      <= violation_d;
    end
  end

  assign last_pkt_len = last_pkt_len_q;
  assign last_gap     = last_gap_q;
  assign min_gap      = min_gap_q;
  assign violation    = violation_q;

endmodule

// File: tb/tb_rate_monitor.sv
// Scoreboard bench for rate_monitor: a timestamp-based reference model predicts
// every cycle's status, and a monitor process compares it one cycle later.
module tb_rate_monitor;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NW = 32;
  localparam longint GAP_MAX = 64'h0000_0000_00FF_FFFF;
  localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          in_wr = 1'b0;
  logic          in_rdy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr;
  logic          out_rdy = 1'b1;
  logic          enable_monitor = 1'b1;
  logic [15:0]   thruput_shift = 16'd0;
  logic          clear_counters = 1'b0;
  logic [NW-1:0] pkt_count;
  logic [NW-1:0] violation_count;
  logic [15:0]   last_pkt_len;
  logic [23:0]   last_gap;
  logic [23:0]   min_gap;
  logic          violation;

  always #5 clk = ~clk;

  rate_monitor #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .enable_monitor(enable_monitor), .thruput_shift(thruput_shift),
    .clear_counters(clear_counters),
    .pkt_count(pkt_count), .violation_count(violation_count),
    .last_pkt_len(last_pkt_len), .last_gap(last_gap), .min_gap(min_gap),
    .violation(violation)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    logic          wr;
    logic          rdy;
    longint        pkt;
    longint        viol;
    longint        last_len;
    longint        last_gap;
    longint        min_gap;
    bit            vio;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  // Stimulus shadows applied together with each driven word.
  logic        t_rst = 1'b1;
  logic        t_en = 1'b1;
  logic [15:0] t_shift = 16'd2;
  logic        t_clr = 1'b0;

  // Reference model: packet boundaries tracked by cycle timestamps.
  int     cyc = 0;
  int     m_mode = 0;
  longint m_len = 0;
  int     m_eop_cyc = 0;
  longint m_req = 0;
  longint m_pkt = 0, m_viol = 0, m_last_len = 0, m_last_gap = 0, m_min_gap = GAP_MAX;
  bit     m_vio = 0;
  bit     m_prev0 = 0;

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  function void chk(input string nm, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, expv);
    end
  endfunction

  function void model_step(input bit wr, input logic [CW-1:0] ctrl);
    bit     eop;
    longint g;
    cyc++;
    if (t_rst) begin
      m_mode = 0; m_len = 0; m_req = 0; m_pkt = 0; m_viol = 0;
      m_last_len = 0; m_last_gap = 0; m_min_gap = GAP_MAX; m_vio = 0; m_prev0 = 0;
      return;
    end
    eop   = wr && (ctrl != 0) && m_prev0;
    m_vio = 0;
    if (!t_en) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (wr) begin m_mode = 1; m_len = 1; end
    end else if (m_mode == 1) begin
      if (wr) begin
        m_len++;
        if (eop) begin
          m_last_len = lmin(m_len, 65535);
          m_pkt      = lmin(m_pkt + 1, CNT_MAX);
          m_req      = lmin(m_last_len * longint'(t_shift), GAP_MAX);
          m_eop_cyc  = cyc;
          m_mode     = 2;
        end
      end
    end else begin
      if (wr) begin
        g = lmin(longint'(cyc - m_eop_cyc - 1), GAP_MAX);
        m_last_gap = g;
        m_min_gap  = lmin(m_min_gap, g);
        if (g < m_req) begin
          m_viol = lmin(m_viol + 1, CNT_MAX);
          m_vio  = 1;
        end
        m_mode = 1;
        m_len  = 1;
      end
    end
    if (t_clr) begin
      m_pkt = 0; m_viol = 0; m_min_gap = GAP_MAX;
    end
    if (wr) m_prev0 = (ctrl == 0);
  endfunction

  task automatic drive(input bit wr, input logic [CW-1:0] ctrl);
    exp_t e;
    @(negedge clk);
    reset          = t_rst;
    enable_monitor = t_en;
    thruput_shift  = t_shift;
    clear_counters = t_clr;
    in_wr          = wr;
    in_ctrl        = ctrl;
    in_data        = {$urandom, $urandom};
    out_rdy        = 1'($urandom_range(0, 1));
    model_step(wr, ctrl);
    t_clr      = 1'b0;
    e.data     = in_data;
    e.ctrl     = in_ctrl;
    e.wr       = in_wr;
    e.rdy      = out_rdy;
    e.pkt      = m_pkt;
    e.viol     = m_viol;
    e.last_len = m_last_len;
    e.last_gap = m_last_gap;
    e.min_gap  = m_min_gap;
    e.vio      = m_vio;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0);
  endtask

  task automatic send_pkt(input int len, input bit clr_last);
    drive(1'b1, 8'hFF);
    for (int i = 1; i < len - 1; i++) drive(1'b1, 8'h00);
    t_clr = clr_last;
    drive(1'b1, 8'($urandom_range(1, 255)));
  endtask

  // Monitor: status is registered, so each pushed expectation is checked just after the next edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("out_data", longint'(out_data), longint'(mon_e.data));
      chk("out_ctrl", longint'(out_ctrl), longint'(mon_e.ctrl));
      chk("out_wr", longint'(out_wr), longint'(mon_e.wr));
      chk("in_rdy", longint'(in_rdy), longint'(mon_e.rdy));
      chk("pkt_count", longint'(pkt_count), mon_e.pkt);
      chk("violation_count", longint'(violation_count), mon_e.viol);
      chk("last_pkt_len", longint'(last_pkt_len), mon_e.last_len);
      chk("last_gap", longint'(last_gap), mon_e.last_gap);
      chk("min_gap", longint'(min_gap), mon_e.min_gap);
      chk("violation", longint'(violation), longint'(mon_e.vio));
    end
  end

  initial begin
    repeat (3) idle(1);
    t_rst = 1'b0;
    idle(2);

    // Conforming gap, then a one-short gap.
    t_shift = 16'd2;
    send_pkt(4, 1'b0); idle(8); send_pkt(4, 1'b0);
    idle(7); send_pkt(4, 1'b0); idle(10);

    // Zero multiplier with back-to-back packets.
    t_shift = 16'd0; t_clr = 1'b1; idle(1);
    repeat (4) send_pkt($urandom_range(3, 6), 1'b0);
    idle(3);

    // Saturated requirement on a long packet.
    t_shift = 16'hFFFF;
    send_pkt(300, 1'b0); idle(50); send_pkt(4, 1'b0); idle(5);

    // Disable mid-packet, re-enable while idle.
    t_shift = 16'd2;
    drive(1'b1, 8'hFF); drive(1'b1, 8'h00); drive(1'b1, 8'h00);
    t_en = 1'b0;
    drive(1'b1, 8'h00); drive(1'b1, 8'h0F); idle(4);
    t_en = 1'b1;
    idle(2); send_pkt(4, 1'b0); idle(3); send_pkt(4, 1'b0); idle(3);

    // Reset mid-gap, then clear coincident with EOP.
    send_pkt(4, 1'b0); idle(3);
    t_rst = 1'b1; idle(2);
    t_rst = 1'b0; idle(2);
    send_pkt(4, 1'b1); idle(3);

    // Random traffic with occasional clears.
    repeat (25) begin
      t_shift = 16'($urandom_range(0, 4));
      send_pkt($urandom_range(3, 12), 1'b0);
      t_clr = ($urandom_range(0, 9) == 0);
      idle($urandom_range(0, 30));
    end
    idle(2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) chk("scoreboard_drain", longint'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
